// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
// Grant and select are registered; y is gated combinationally from them.

module mux_rr_lane #(
   parameter int WIDTH = 1,
   parameter int IDX   = 0
) (
   input  logic             valid,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] y
);
   assign y = (valid && (sel == 2'(IDX))) ? din : '0;
endmodule

module mux_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic [WIDTH-1:0] din3,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic             valid,
   output logic [WIDTH-1:0] y
);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [CW-1:0] cnt;

   logic [3:0] others;
   logic [1:0] win_any, win_oth;

   // Lowest offset from p wins: scan backwards so the nearest hit is written last.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign others  = req & ~(4'b0001 << sel);
   assign win_any = rr_pick(req, ptr);
   assign win_oth = rr_pick(others, ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= GRANT;
                  gnt   <= 4'b0001 << win_any;
                  sel   <= win_any;
                  ptr   <= win_any + 2'd1;
                  cnt   <= '0;
               end
            end
            GRANT: begin
               // Release or exhausted hold both hand over directly when someone waits.
               if ((!req[sel] || cnt == CNT_MAX) && |others) begin
                  gnt <= 4'b0001 << win_oth;
                  sel <= win_oth;
                  ptr <= win_oth + 2'd1;
                  cnt <= '0;
               end else if (!req[sel]) begin
                  state <= IDLE;
                  gnt   <= '0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign valid = |gnt;

   logic [3:0][WIDTH-1:0] din_arr, lane_y;
   assign din_arr = {din3, din2, din1, din0};

   for (genvar i = 0; i < 4; i++) begin : g_lane
      mux_rr_lane #(.WIDTH(WIDTH), .IDX(i)) u_lane (
         .valid (valid),
         .sel   (sel),
         .din   (din_arr[i]),
         .y     (lane_y[i])
      );
   end

   assign y = lane_y[0] | lane_y[1] | lane_y[2] | lane_y[3];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD 4 and 1) checked every cycle
// against an owner/hold-count model, plus directed literal expectations.

module tb_mux_rr_arbiter;
   logic       clk = 0;
   logic       rst = 1;
   logic [3:0] req = '0;
   logic [3:0] din [4];

   logic [3:0] gnt4, gnt1;
   logic [1:0] sel4, sel1;
   logic       valid4, valid1;
   logic [3:0] y4;
   logic [0:0] y1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) u4 (
      .clk(clk), .rst(rst), .req(req),
      .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
      .gnt(gnt4), .sel(sel4), .valid(valid4), .y(y4)
   );

   mux_rr_arbiter #(.WIDTH(1), .MAX_HOLD(1)) u1 (
      .clk(clk), .rst(rst), .req(req),
      .din0(din[0][0]), .din1(din[1][0]), .din2(din[2][0]), .din3(din[3][0]),
      .gnt(gnt1), .sel(sel1), .valid(valid1), .y(y1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: owner index (-1 idle), cycles owned, next scan start, last select.
   int m_own   [2];
   int m_held  [2];
   int m_start [2];
   int m_sel   [2];
   int mh      [2] = '{4, 1};
   bit model_ok = 0;

   function automatic int scan(input logic [3:0] r, input int s);
      for (int k = 0; k < 4; k++)
         if (r[(s + k) % 4]) return (s + k) % 4;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      for (int i = 0; i < 2; i++) begin
         int w;
         logic [3:0] oth;
         if (rst) begin
            m_own[i] <= -1; m_held[i] <= 0; m_start[i] <= 0; m_sel[i] <= 0;
         end else if (m_own[i] < 0) begin
            w = scan(req, m_start[i]);
            if (w >= 0) begin
               m_own[i] <= w; m_sel[i] <= w; m_held[i] <= 1; m_start[i] <= (w + 1) % 4;
            end
         end else begin
            oth = req & ~(4'b0001 << m_own[i]);
            w = scan(oth, m_start[i]);
            if ((!req[m_own[i]] || m_held[i] >= mh[i]) && w >= 0) begin
               m_own[i] <= w; m_sel[i] <= w; m_held[i] <= 1; m_start[i] <= (w + 1) % 4;
            end else if (!req[m_own[i]]) begin
               m_own[i] <= -1;
            end else begin
               m_held[i] <= m_held[i] + 1;
            end
         end
      end
      if (rst) model_ok <= 1;
   end

   always @(negedge clk) begin : compare
      logic [3:0] eg;
      logic [3:0] ey;
      if (model_ok) begin
         eg = (m_own[0] < 0) ? 4'b0 : (4'b0001 << m_own[0]);
         ey = (m_own[0] < 0) ? 4'b0 : din[m_sel[0]];
         chk("m4.gnt",   32'(gnt4),   32'(eg));
         chk("m4.sel",   32'(sel4),   32'(m_sel[0]));
         chk("m4.valid", 32'(valid4), 32'(m_own[0] >= 0));
         chk("m4.y",     32'(y4),     32'(ey));
         eg = (m_own[1] < 0) ? 4'b0 : (4'b0001 << m_own[1]);
         ey = (m_own[1] < 0) ? 4'b0 : {3'b0, din[m_sel[1]][0]};
         chk("m1.gnt",   32'(gnt1),   32'(eg));
         chk("m1.sel",   32'(sel1),   32'(m_sel[1]));
         chk("m1.valid", 32'(valid1), 32'(m_own[1] >= 0));
         chk("m1.y",     32'(y1),     32'(ey));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      req = '0;
      repeat (n) step();
      rst = 0;
   endtask

   logic [3:0] tbl [24] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                            4'b0000, 4'b1100, 4'b1100, 4'b0110, 4'b0110, 4'b0110,
                            4'b0110, 4'b0110, 4'b1001, 4'b0000, 4'b1111, 4'b0010};

   initial begin
      for (int i = 0; i < 4; i++) din[i] = '0;

      // Reset then idle
      rst = 1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("rst.gnt", 32'(gnt4), 0);
         chk("rst.sel", 32'(sel4), 0);
         chk("rst.valid", 32'(valid4), 0);
         chk("rst.y", 32'(y4), 0);
      end
      rst = 0;
      step();
      chk("idle.gnt", 32'(gnt4), 0);

      // Single request from requester 1
      din[1] = 4'h1;
      req = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("single.gnt", 32'(gnt4), 32'h2);
         chk("single.sel", 32'(sel4), 1);
         chk("single.y", 32'(y4), 1);
      end
      req = 4'b0000;
      step();
      chk("single.release", 32'(gnt4), 0);
      chk("single.sel_hold", 32'(sel4), 1);

      // Round-robin fairness with all requests held
      do_reset(1);
      req = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         step();
         chk("rr4.gnt", 32'(gnt4), 32'(4'b0001 << ((k / 4) % 4)));
         chk("rr4.sel", 32'(sel4), 32'((k / 4) % 4));
         chk("rr1.gnt", 32'(gnt1), 32'(4'b0001 << (k % 4)));
      end

      // Early release: 0 drops, 2 takes over with no idle bubble
      do_reset(1);
      din[2] = 4'hA;
      req = 4'b0101;
      step();
      chk("early.g0a", 32'(gnt4), 32'h1);
      step();
      chk("early.g0b", 32'(gnt4), 32'h1);
      req = 4'b0100;
      step();
      chk("early.gnt", 32'(gnt4), 32'h4);
      chk("early.sel", 32'(sel4), 2);
      chk("early.y", 32'(y4), 32'hA);

      // Reset mid-grant
      do_reset(1);
      req = 4'b1000;
      step();
      chk("midrst.g3", 32'(gnt4), 32'h8);
      rst = 1;
      req = 4'b1111;
      step();
      chk("midrst.gnt", 32'(gnt4), 0);
      chk("midrst.sel", 32'(sel4), 0);
      chk("midrst.valid", 32'(valid4), 0);
      rst = 0;
      step();
      chk("midrst.next", 32'(gnt4), 32'h1);

      // Data path at MAX_HOLD = 1
      din[0] = 4'h0; din[1] = 4'h1; din[2] = 4'h0; din[3] = 4'h1;
      do_reset(1);
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("dp.y", 32'(y1), 32'(k % 2));
         chk("dp.valid", 32'(valid1), 1);
      end

      // Mixed table; din changes mid-cycle to exercise combinational y
      do_reset(1);
      for (int t = 0; t < 24; t++) begin
         req = tbl[t];
         for (int i = 0; i < 4; i++) din[i] = 4'($urandom);
         step();
         if (t == 6) chk("late_contention.gnt", 32'(gnt4), 32'h2);
         @(negedge clk);
         #1;
         for (int i = 0; i < 4; i++) din[i] = 4'($urandom);
      end
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
